// File: rtl/mz_pkg.sv
// Shared definitions for the Mach-Zehnder readout: state encoding, sequencer
// timing defaults and result width default.
package mz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_DELAY,
    ST_WINDOW,
    ST_HOLD
  } mz_state_e;

  // Pulse sequencer timing defaults: inter-pulse gap, pi/2 and pi durations.
  localparam int SEQ_GAP_CYCLES = 1000;
  localparam int SEQ_PI2_CYCLES = 333;
  localparam int SEQ_PI_CYCLES  = 666;

  localparam int PHOT_W_DEF = 16;

endpackage

// File: rtl/mz_readout_sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous level, followed by a registered
// one-cycle pulse on each synchronised rising edge.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              pulse_q, pulse_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = async_in;
    prev_d    = sync_q[STAGES-1];
    pulse_d   = sync_q[STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign rise_pulse = pulse_q;

endmodule

// File: rtl/mz_readout.sv
// Mach-Zehnder shot readout: counts rf pulses of a shot, waits a fixed delay,
// counts detector edges in a window and offers the result over valid/ready.
module mz_readout
  import mz_pkg::*;
#(
  parameter int PULSES_PER_SHOT = 3,
  parameter int DET_DELAY       = 100,
  parameter int DET_WINDOW      = 1000,
  parameter int GAP_TIMEOUT     = 2048,
  parameter int PHOT_W          = PHOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rf,
  input  logic              photon_in,
  output logic [PHOT_W-1:0] shot_count,
  output logic              shot_sat,
  output logic              shot_overlap,
  output logic              shot_valid,
  input  logic              shot_ready,
  output logic              gap_err,
  output logic              shot_dropped,
  output logic              busy
);

  localparam int PI_W  = $clog2(PULSES_PER_SHOT + 1);
  localparam int GAP_W = $clog2(GAP_TIMEOUT) + 1;

  localparam logic [PI_W-1:0]   LAST_IDX = PI_W'(PULSES_PER_SHOT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [15:0]       DLY_LAST = 16'(DET_DELAY - 1);
  localparam logic [15:0]       WIN_LAST = 16'(DET_WINDOW - 1);
  localparam logic [PHOT_W-1:0] CNT_MAX  = '1;

  mz_state_e         state_q, state_d;
  logic              rf_q, rf_d;
  logic [PI_W-1:0]   pulse_idx_q, pulse_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [PHOT_W-1:0] count_q, count_d;
  logic              sat_q, sat_d;
  logic              ovl_q, ovl_d;
  logic              valid_q, valid_d;
  logic              gap_err_q, gap_err_d;
  logic              dropped_q, dropped_d;

  logic rf_rise, rf_fall, photon_ev;

  sync_edge_det #(.STAGES(2)) u_photon_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (photon_in),
    .rise_pulse (photon_ev)
  );

  assign rf_rise = rf & ~rf_q;
  assign rf_fall = ~rf & rf_q;

  // Result handshake: shot_valid holds with stable count/sat/overlap until a
  // cycle with shot_valid && shot_ready; that cycle is the transfer.
  always_comb begin
    state_d     = state_q;
    rf_d        = rf;
    pulse_idx_d = pulse_idx_q;
    gap_cnt_d   = gap_cnt_q;
    tmr_d       = tmr_q;
    count_d     = count_q;
    sat_d       = sat_q;
    ovl_d       = ovl_q;
    valid_d     = valid_q;
    gap_err_d   = 1'b0;
    dropped_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_ARM;
          pulse_idx_d = '0;
          gap_cnt_d   = '0;
          count_d     = '0;
          sat_d       = 1'b0;
          ovl_d       = 1'b0;
        end
      end

      ST_ARM: begin
        if (!enable) begin
          state_d     = ST_IDLE;
          pulse_idx_d = '0;
          gap_cnt_d   = '0;
        end else if (rf_fall && pulse_idx_q == LAST_IDX) begin
          state_d     = ST_DELAY;
          tmr_d       = '0;
          pulse_idx_d = '0;
          gap_cnt_d   = '0;
        end else begin
          if (rf_fall) pulse_idx_d = pulse_idx_q + PI_W'(1);
          // Gap time is counted from the fall of the first pulse onwards.
          if (rf_rise) begin
            gap_cnt_d = '0;
          end else if (!rf && (pulse_idx_q != '0 || rf_fall)) begin
            if (gap_cnt_q == GAP_LAST) begin
              gap_err_d   = 1'b1;
              pulse_idx_d = '0;
              gap_cnt_d   = '0;
            end else begin
              gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
          end
        end
      end

      ST_DELAY: begin
        if (!enable) begin
          state_d = ST_IDLE;
          ovl_d   = 1'b0;
        end else begin
          if (rf_rise) ovl_d = 1'b1;
          if (tmr_q == DLY_LAST) begin
            state_d = ST_WINDOW;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
      end

      ST_WINDOW: begin
        if (!enable) begin
          state_d = ST_IDLE;
          count_d = '0;
          sat_d   = 1'b0;
          ovl_d   = 1'b0;
        end else begin
          if (rf_rise) ovl_d = 1'b1;
          if (photon_ev && count_q != CNT_MAX) begin
            count_d = count_q + PHOT_W'(1);
            if (count_q + PHOT_W'(1) == CNT_MAX) sat_d = 1'b1;
          end
          if (tmr_q == WIN_LAST) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
      end

      ST_HOLD: begin
        if (rf_rise) dropped_d = 1'b1;
        if (valid_q && shot_ready) begin
          valid_d = 1'b0;
          if (enable) begin
            state_d     = ST_ARM;
            pulse_idx_d = '0;
            gap_cnt_d   = '0;
            count_d     = '0;
            sat_d       = 1'b0;
            ovl_d       = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rf_q        <= 1'b0;
      pulse_idx_q <= '0;
      gap_cnt_q   <= '0;
      tmr_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      ovl_q       <= 1'b0;
      valid_q     <= 1'b0;
      gap_err_q   <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      pulse_idx_q <= pulse_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      tmr_q       <= tmr_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      ovl_q       <= ovl_d;
      valid_q     <= valid_d;
      gap_err_q   <= gap_err_d;
      dropped_q   <= dropped_d;
    end
  end

  assign shot_count   = count_q;
  assign shot_sat     = sat_q;
  assign shot_overlap = ovl_q;
  assign shot_valid   = valid_q;
  assign gap_err      = gap_err_q;
  assign shot_dropped = dropped_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mz_readout.sv
// Bench for mz_readout: a 16-bit and a 4-bit instance share stimulus; a
// monitor pops expected results from a queue on each accepted shot.
module tb_mz_readout;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic rf = 1'b0;
  logic photon_in = 1'b0;
  logic shot_ready = 1'b0;

  logic [15:0] cnt_a;
  logic        sat_a, ovl_a, valid_a, gap_a, drop_a, busy_a;
  logic [3:0]  cnt_b;
  logic        sat_b, ovl_b, valid_b, gap_b, drop_b, busy_b;

  int n_vec = 0;
  int n_err = 0;
  int n_gap = 0;
  int n_drop = 0;

  // Packed expectation: {ovl, sat4, cnt4[3:0], sat16, cnt16[15:0]}
  logic [22:0] exp_q[$];
  logic [22:0] mon_e;

  always #5 clk = ~clk;

  mz_readout #(
    .PULSES_PER_SHOT(3), .DET_DELAY(100), .DET_WINDOW(1000),
    .GAP_TIMEOUT(2048), .PHOT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rf(rf), .photon_in(photon_in),
    .shot_count(cnt_a), .shot_sat(sat_a), .shot_overlap(ovl_a),
    .shot_valid(valid_a), .shot_ready(shot_ready), .gap_err(gap_a),
    .shot_dropped(drop_a), .busy(busy_a)
  );

  mz_readout #(
    .PULSES_PER_SHOT(3), .DET_DELAY(100), .DET_WINDOW(1000),
    .GAP_TIMEOUT(2048), .PHOT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rf(rf), .photon_in(photon_in),
    .shot_count(cnt_b), .shot_sat(sat_b), .shot_overlap(ovl_b),
    .shot_valid(valid_b), .shot_ready(shot_ready), .gap_err(gap_b),
    .shot_dropped(drop_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] mk_exp(input int n, input logic ovl);
    logic [15:0] c16;
    logic        s16;
    logic [3:0]  c4;
    logic        s4;
    s16 = (n >= 65535);
    c16 = s16 ? 16'hffff : 16'(n);
    s4  = (n >= 15);
    c4  = s4 ? 4'hf : 4'(n);
    return {ovl, s4, c4, s16, c16};
  endfunction

  // Monitor: counts status pulses and scores every accepted shot.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gap_a) n_gap++;
      if (drop_a) n_drop++;
      if (valid_a && shot_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_shot: got count %0d with no expected entry", cnt_a);
        end else begin
          mon_e = exp_q.pop_front();
          check("shot_count16", 32'(cnt_a), 32'(mon_e[15:0]));
          check("shot_sat16", 32'(sat_a), 32'(mon_e[16]));
          check("shot_count4", 32'(cnt_b), 32'(mon_e[20:17]));
          check("shot_sat4", 32'(sat_b), 32'(mon_e[21]));
          check("shot_overlap", 32'({ovl_a, ovl_b}), 32'({mon_e[22], mon_e[22]}));
          check("shot_valid4", 32'(valid_b), 32'(valid_a));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d vectors %0d miscompares so far", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rf_shot(input int lo1, input int hi1, input int lo2,
                         input int hi2, input int lo3, input int hi3);
    rf = 1'b0; tick(lo1);
    rf = 1'b1; tick(hi1);
    rf = 1'b0; tick(lo2);
    rf = 1'b1; tick(hi2);
    rf = 1'b0; tick(lo3);
    rf = 1'b1; tick(hi3);
    rf = 1'b0;
  endtask

  task automatic short_shot();
    rf_shot(20, 30, 40, 50, 40, 30);
  endtask

  // Called right after the last rf fall; drives photons (3-cycle pulses every
  // 15 cycles) and an optional rf pulse, and checks the valid latency.
  task automatic wait_shot(input string name, input int ph_start, input int n_ph, input int rf_at);
    int k;
    bit seen;
    k = 0;
    seen = 0;
    while (!seen && k < 1300) begin
      photon_in = (n_ph > 0 && k >= ph_start && k < ph_start + 15 * n_ph &&
                   ((k - ph_start) % 15) < 3);
      rf = (rf_at > 0 && k >= rf_at && k < rf_at + 10);
      tick();
      k++;
      if (valid_a) seen = 1;
    end
    photon_in = 1'b0;
    rf = 1'b0;
    check({name, "_latency"}, 32'(k), 32'd1101);
  endtask

  task automatic check_zero(input string name);
    check({name, "_a"}, 32'({cnt_a, sat_a, ovl_a, valid_a, gap_a, drop_a, busy_a}), 32'd0);
    check({name, "_b"}, 32'({cnt_b, sat_b, ovl_b, valid_b, gap_b, drop_b, busy_b}), 32'd0);
  endtask

  initial begin
    int k;
    int drop0;
    int gap0;
    bit seen;

    // Reset state
    #1;
    check_zero("reset");
    tick(3);
    rst_n = 1'b1;
    tick(2);
    enable = 1'b1;
    shot_ready = 1'b1;
    tick(5);

    // Nominal sequencer-style shot, 50 photons
    exp_q.push_back(mk_exp(50, 1'b0));
    rf_shot(1000, 334, 1001, 667, 1001, 334);
    wait_shot("nominal", 150, 50, 0);
    tick(5);

    // Backpressure: result held for 500 cycles with photons and rf in HOLD
    shot_ready = 1'b0;
    exp_q.push_back(mk_exp(10, 1'b0));
    short_shot();
    wait_shot("bp", 200, 10, 0);
    drop0 = n_drop;
    for (int j = 0; j < 500; j++) begin
      photon_in = (j < 75 && (j % 15) < 3);
      rf = ((j >= 100 && j < 105) || (j >= 300 && j < 305));
      tick();
    end
    photon_in = 1'b0;
    rf = 1'b0;
    check("bp_valid_held", 32'(valid_a), 32'd1);
    check("bp_count_held", 32'(cnt_a), 32'd10);
    shot_ready = 1'b1;
    tick();
    check("bp_accept", 32'({valid_a, busy_a}), 32'b01);
    check("bp_dropped", 32'(n_drop - drop0), 32'd2);
    tick(5);

    // Gap timeout after two pulses
    gap0 = n_gap;
    rf = 1'b0; tick(20);
    rf = 1'b1; tick(30);
    rf = 1'b0; tick(40);
    rf = 1'b1; tick(50);
    rf = 1'b0;
    k = 0;
    seen = 0;
    while (!seen && k < 2200) begin
      tick();
      k++;
      if (gap_a) seen = 1;
    end
    check("gap_cycle", 32'(k), 32'd2048);
    tick();
    check("gap_pulses", 32'(n_gap - gap0), 32'd1);
    tick(10);

    // Full shot after timeout; 20 photons also saturate the 4-bit instance
    exp_q.push_back(mk_exp(20, 1'b0));
    short_shot();
    wait_shot("post_gap", 200, 20, 0);
    tick(5);

    // rf pulse during DELAY sets overlap
    exp_q.push_back(mk_exp(0, 1'b1));
    short_shot();
    wait_shot("overlap", 0, 0, 50);
    tick(5);

    // enable dropped in WINDOW: abort, no result
    short_shot();
    tick(600);
    enable = 1'b0;
    tick();
    check("abort_busy", 32'({busy_a, busy_b}), 32'd0);
    seen = 0;
    for (int j = 0; j < 1200; j++) begin
      tick();
      if (valid_a || valid_b) seen = 1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    enable = 1'b1;
    tick(5);

    // Async reset mid-WINDOW, then clean restart
    short_shot();
    for (int j = 0; j < 500; j++) begin
      photon_in = (j >= 150 && ((j - 150) % 15) < 3);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_zero("rst_window");
    photon_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    exp_q.push_back(mk_exp(5, 1'b0));
    short_shot();
    wait_shot("restart_window", 300, 5, 0);
    tick(5);

    // Async reset mid-HOLD drops the pending result
    shot_ready = 1'b0;
    exp_q.push_back(mk_exp(7, 1'b0));
    short_shot();
    wait_shot("hold_shot", 200, 7, 0);
    tick(10);
    rst_n = 1'b0;
    #1;
    check_zero("rst_hold");
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    shot_ready = 1'b1;
    tick(3);
    exp_q.push_back(mk_exp(3, 1'b0));
    short_shot();
    wait_shot("restart_hold", 200, 3, 0);
    tick(5);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("gap_total", 32'(n_gap), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mz_readout.md
Name: mz_readout

Overview:
- Sits directly downstream of the RF pulse sequencer. It consumes the sequencer's rf gate output.
- It tracks the three-pulse Mach-Zehnder shot (pi/2, pi, pi/2) by counting completed rf pulses.
- After the final pulse it waits a fixed delay, then opens a detection window and counts photon-detector edges.
- It hands each shot's count to the acquisition logic over a valid/ready interface.

Parameters:
- PULSES_PER_SHOT, 3, rf pulses that make up one shot.
- DET_DELAY, 100, cycles from the last rf falling edge to the window opening (range 1..2^16-1).
- DET_WINDOW, 1000, detection window length in cycles (range 1..2^16-1).
- GAP_TIMEOUT, 2048, maximum rf-low cycles allowed between pulses of one shot.
- PHOT_W, 16, photon count width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arms shot capture.
- rf  in  1  rf gate from the pulse sequencer (same clock domain).
- photon_in  in  1  detector pulse, asynchronous, minimum high time 2 clk.
- shot_count  out  PHOT_W  photons counted in the window.
- shot_sat  out  1  count saturated at 2^PHOT_W-1.
- shot_overlap  out  1  an rf rising edge occurred during DELAY or WINDOW.
- shot_valid  out  1  result valid.
- shot_ready  in  1  consumer accepts the result.
- gap_err  out  1  one-cycle pulse: a shot was aborted on gap timeout.
- shot_dropped  out  1  one-cycle pulse: an rf rising edge arrived while in HOLD.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-shot aborts immediately with no result.
- rf edge detection: compare rf against its registered copy, one cycle of latency.
- photon_in path:
  - 2-FF synchroniser, then rising-edge detect.
  - A detector edge appears as a counted event 3 cycles later.
- IDLE: when enable=1, go to ARM and clear pulse_idx, gap_cnt and the result fields.
- ARM:
  - Each detected rf falling edge increments pulse_idx.
  - When the falling edge makes pulse_idx = PULSES_PER_SHOT, go to DELAY.
  - gap_cnt runs while rf=0 and pulse_idx>=1. It clears on every rf rising edge.
  - When gap_cnt reaches GAP_TIMEOUT: pulse gap_err, set pulse_idx=0, stay in ARM.
  - rf high before the first pulse has no timeout.
- DELAY:
  - Lasts exactly DET_DELAY cycles, then go to WINDOW.
  - An rf rising edge here sets shot_overlap.
- WINDOW:
  - Lasts exactly DET_WINDOW cycles.
  - Each synchronised photon edge increments shot_count, saturating at all-ones and setting shot_sat.
  - An rf rising edge here sets shot_overlap.
  - On the cycle after the last window cycle, go to HOLD with shot_valid=1.
- HOLD:
  - shot_count, shot_sat and shot_overlap stay stable while shot_valid=1 and shot_ready=0.
  - Photons are ignored.
  - When shot_valid && shot_ready: drop shot_valid next cycle, then go to ARM if enable=1, else IDLE.
  - shot_ready may be held high continuously; HOLD then lasts 1 cycle.
  - Each rf rising edge in HOLD pulses shot_dropped.
- enable deasserted:
  - In ARM, DELAY or WINDOW: go to IDLE next cycle, discard the partial shot, raise no error.
  - In HOLD: ignored; the handshake completes first.
- Simultaneous events:
  - A photon edge on the final WINDOW cycle is counted.
  - An rf rising edge on the cycle ARM exits is attributed to DELAY, so shot_overlap is set.
  - gap timeout and a rising edge in the same cycle: the rising edge wins, no error.
- Counters: delay and window counters are 16 bits; gap_cnt is clog2(GAP_TIMEOUT)+1 bits.

Decomposition:
- Shared package mz_pkg holds:
  - the readout state enum (IDLE, ARM, DELAY, WINDOW, HOLD);
  - default timing constants shared with the pulse sequencer (1000/333/666 cycle durations);
  - the PHOT_W default.
- One sub-module: sync_edge_det (2-FF synchroniser plus rising-edge pulse, parameterised stage count). It is used for photon_in.

Test Plan:
- Nominal shot: sequencer-style rf (1000 low, 334 high, 1001 low, 667 high, 1001 low, 334 high), 50 photon pulses spaced 15 cycles inside the window, shot_ready=1. Required: shot_valid 1+100+1000 cycles after the last rf fall, shot_count=50, shot_sat=0, shot_overlap=0.
- Backpressure: shot_ready=0 for 500 cycles, with 5 photons and 2 rf pulses during HOLD. Required: count stays stable, shot_dropped pulses twice, the result is accepted on the cycle shot_ready rises.
- Gap timeout: two rf pulses, then rf low for 2048 cycles. Required: gap_err pulse on cycle 2048, pulse_idx reset, and a following full sequence yields a valid shot.
- Saturation (PHOT_W=4): 20 photons in the window. Required: shot_count=15, shot_sat=1.
- Abort and overlap:
  - Drop enable in WINDOW. Required: IDLE next cycle, busy=0, no shot_valid.
  - rf pulse during DELAY. Required: shot_overlap=1 on the delivered result.
- Async reset asserted mid-WINDOW and mid-HOLD. Required: all outputs 0 immediately, a clean restart after release with enable=1.
